// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 8-bit registered arithmetic/logic unit
//
// Computes one of eight operations on operands a and b, selected by s, and
// registers a 16-bit result plus four status flags. One-cycle latency, a new
// operation every cycle, no handshake.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous active-high reset (clears o and flags)
//   a              in   8   operand A
//   b              in   8   operand B (shifts use only b[2:0])
//   s              in   3   opcode: ADD SUB MUL AND OR XOR SHL SHR
//   o              out 16   registered result
//   zero_flag      out  1   registered: o == 0
//   carry_flag     out  1   registered carry / borrow / shifted-out bit
//   sign_flag      out  1   registered sign of the result
//   overflow_flag  out  1   registered signed overflow
// ---------------------------------------------------------------------------
module alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [2:0]  s,
   output logic [15:0] o,
   output logic        zero_flag,
   output logic        carry_flag,
   output logic        sign_flag,
   output logic        overflow_flag
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   logic [8:0]  w_sum;
   logic [8:0]  w_diff;
   logic [15:0] w_prod;
   logic [2:0]  w_n;
   logic [8:0]  w_shl;
   logic [8:0]  w_shr;

   logic [15:0] w_res;
   logic        w_carry;
   logic        w_sign;
   logic        w_ovf;

   logic [15:0] r_o;
   logic        r_zero;
   logic        r_carry;
   logic        r_sign;
   logic        r_ovf;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   // 9-bit difference: bit 8 is set exactly when a < b (unsigned borrow).
   assign w_diff = {1'b0, a} - {1'b0, b};
   assign w_prod = {8'b0, a} * {8'b0, b};
   assign w_n    = b[2:0];
   // A guard bit on each side catches the last bit shifted out; with n == 0
   // the guard stays 0, giving carry = 0 for free.
   assign w_shl  = {1'b0, a} << w_n;
   assign w_shr  = {a, 1'b0} >> w_n;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would infer a latch.
      w_res   = 16'h0000;
      w_carry = 1'b0;
      w_sign  = 1'b0;
      w_ovf   = 1'b0;
      unique case (op_e'(s))
         OP_ADD: begin
            w_res   = {7'b0, w_sum};
            w_carry = w_sum[8];
            w_sign  = w_sum[7];
            w_ovf   = (a[7] == b[7]) && (w_sum[7] != a[7]);
         end
         OP_SUB: begin
            w_res   = {8'b0, w_diff[7:0]};
            w_carry = w_diff[8];
            w_sign  = w_diff[7];
            w_ovf   = (a[7] != b[7]) && (w_diff[7] != a[7]);
         end
         OP_MUL: begin
            w_res   = w_prod;
            w_carry = |w_prod[15:8];
            w_sign  = w_prod[15];
            w_ovf   = |w_prod[15:8];
         end
         OP_AND: begin
            w_res  = {8'b0, a & b};
            w_sign = a[7] & b[7];
         end
         OP_OR: begin
            w_res  = {8'b0, a | b};
            w_sign = a[7] | b[7];
         end
         OP_XOR: begin
            w_res  = {8'b0, a ^ b};
            w_sign = a[7] ^ b[7];
         end
         OP_SHL: begin
            w_res   = {8'b0, w_shl[7:0]};
            w_carry = w_shl[8];
            w_sign  = w_shl[7];
         end
         OP_SHR: begin
            w_res   = {8'b0, w_shr[8:1]};
            w_carry = w_shr[0];
            w_sign  = w_shr[8];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         r_o     <= 16'h0000;
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
         r_sign  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_o     <= w_res;
         r_zero  <= (w_res == 16'h0000);
         r_carry <= w_carry;
         r_sign  <= w_sign;
         r_ovf   <= w_ovf;
      end
   end

   assign o             = r_o;
   assign zero_flag     = r_zero;
   assign carry_flag    = r_carry;
   assign sign_flag     = r_sign;
   assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- scoreboard testbench for alu
//
// The driver applies one vector per cycle on the falling edge and pushes the
// hand-computed response into a queue. The monitor, 1 time unit after each
// rising edge, pops one entry whenever the queue holds one and compares it
// against the registered outputs.
// ---------------------------------------------------------------------------
module tb_alu;

   typedef struct {
      string       name;
      logic [15:0] o;
      logic        z;
      logic        c;
      logic        sg;
      logic        ov;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [2:0]  s;
   logic [15:0] o;
   logic        zero_flag;
   logic        carry_flag;
   logic        sign_flag;
   logic        overflow_flag;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 1'b0;

   alu dut (
      .clk           (clk),
      .rst           (rst),
      .a             (a),
      .b             (b),
      .s             (s),
      .o             (o),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .sign_flag     (sign_flag),
      .overflow_flag (overflow_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got o=%h z=%b c=%b s=%b v=%b, expected o=%h z=%b c=%b s=%b v=%b",
                  name, act[19:4], act[3], act[2], act[1], act[0],
                  exp[19:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // One vector per cycle; expected outputs are those seen after the next edge.
   task automatic issue(input string name, input logic r, input logic [7:0] ia,
                        input logic [7:0] ib, input logic [2:0] is,
                        input logic [15:0] eo, input logic ez, input logic ec,
                        input logic es, input logic ev);
      exp_t e;
      @(negedge clk);
      rst = r;
      a   = ia;
      b   = ib;
      s   = is;
      e.name = name;
      e.o = eo; e.z = ez; e.c = ec; e.sg = es; e.ov = ev;
      q.push_back(e);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, {o, zero_flag, carry_flag, sign_flag, overflow_flag},
                  {e.o, e.z, e.c, e.sg, e.ov});
         end
      end
   end

   // Driver
   initial begin
      rst = 1'b1; a = 8'd0; b = 8'd0; s = 3'd0;

      // Reset dominates an active MUL, then the MUL appears one edge later.
      issue("rst0",        1, 8'd255, 8'd255, 3'b010, 16'h0000, 0, 0, 0, 0);
      issue("rst1",        1, 8'd255, 8'd255, 3'b010, 16'h0000, 0, 0, 0, 0);
      issue("mul_ff_ff",   0, 8'd255, 8'd255, 3'b010, 16'hFE01, 0, 1, 1, 1);

      // Zero operands through every opcode.
      for (int i = 0; i < 8; i++)
         issue($sformatf("zero_op%0d", i), 0, 8'd0, 8'd0, 3'(i), 16'h0000, 1, 0, 0, 0);

      // a=5, b=7
      issue("add_5_7",     0, 8'd5, 8'd7, 3'b000, 16'h000C, 0, 0, 0, 0);
      issue("sub_5_7",     0, 8'd5, 8'd7, 3'b001, 16'h00FE, 0, 1, 1, 0);
      issue("mul_5_7",     0, 8'd5, 8'd7, 3'b010, 16'h0023, 0, 0, 0, 0);
      issue("and_5_7",     0, 8'd5, 8'd7, 3'b011, 16'h0005, 0, 0, 0, 0);
      issue("or_5_7",      0, 8'd5, 8'd7, 3'b100, 16'h0007, 0, 0, 0, 0);
      issue("xor_5_7",     0, 8'd5, 8'd7, 3'b101, 16'h0002, 0, 0, 0, 0);
      issue("shl_5_7",     0, 8'd5, 8'd7, 3'b110, 16'h0080, 0, 0, 1, 0);
      issue("shr_5_7",     0, 8'd5, 8'd7, 3'b111, 16'h0000, 1, 0, 0, 0);

      // a=127, b=63
      issue("add_127_63",  0, 8'd127, 8'd63, 3'b000, 16'h00BE, 0, 0, 1, 1);
      issue("sub_127_63",  0, 8'd127, 8'd63, 3'b001, 16'h0040, 0, 0, 0, 0);
      issue("mul_127_63",  0, 8'd127, 8'd63, 3'b010, 16'h1F41, 0, 1, 0, 1);

      // a=127, b=200
      issue("sub_127_200", 0, 8'd127, 8'd200, 3'b001, 16'h00B7, 0, 1, 1, 1);
      issue("add_127_200", 0, 8'd127, 8'd200, 3'b000, 16'h0147, 0, 1, 0, 0);
      issue("and_127_200", 0, 8'd127, 8'd200, 3'b011, 16'h0048, 0, 0, 0, 0);

      // a=255, b=255
      issue("add_ff_ff",   0, 8'd255, 8'd255, 3'b000, 16'h01FE, 0, 1, 1, 0);
      issue("sub_ff_ff",   0, 8'd255, 8'd255, 3'b001, 16'h0000, 1, 0, 0, 0);
      issue("xor_ff_ff",   0, 8'd255, 8'd255, 3'b101, 16'h0000, 1, 0, 0, 0);
      issue("shl_ff_n7",   0, 8'd255, 8'd255, 3'b110, 16'h0080, 0, 1, 1, 0);

      // Shift details: b[7:3] ignored, carry from the last bit shifted out.
      issue("shl_81_n1",   0, 8'h81, 8'hF9, 3'b110, 16'h0002, 0, 1, 0, 0);
      issue("shr_81_n1",   0, 8'h81, 8'h09, 3'b111, 16'h0040, 0, 1, 0, 0);
      issue("shr_80_n0",   0, 8'h80, 8'hF8, 3'b111, 16'h0080, 0, 0, 1, 0);
      issue("shr_0c_n3",   0, 8'h0C, 8'h03, 3'b111, 16'h0001, 0, 1, 0, 0);
      issue("mul_0_9",     0, 8'd0, 8'd9, 3'b010, 16'h0000, 1, 0, 0, 0);
      issue("sub_80_01",   0, 8'h80, 8'h01, 3'b001, 16'h007F, 0, 0, 0, 1);

      // Reset in the middle of a back-to-back stream.
      issue("pre_rst_add", 0, 8'd100, 8'd100, 3'b000, 16'h00C8, 0, 0, 1, 1);
      issue("mid_rst",     1, 8'd255, 8'd255, 3'b000, 16'h0000, 0, 0, 0, 0);
      issue("post_rst_or", 0, 8'hF0, 8'h0F, 3'b100, 16'h00FF, 0, 0, 1, 0);
      issue("post_rst_mul",0, 8'd16, 8'd16, 3'b010, 16'h0100, 0, 1, 0, 1);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d responses still pending, expected 0", q.size());
      end
      done = 1'b1;
   end

   initial begin
      fork
         wait (done);
         #100000;
      join_any
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL timeout: driver did not complete, expected completion");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
